id_ex_bubble_reg: RTL and testbench
===================================

# id_ex_bubble_reg

Parametrised ID/EX pipeline register with built-in bubble insertion, the next generation of the decode-stage control mux. It captures the decoded control bundle, instruction and PC each cycle. It replaces the bundle with an all-zero bubble on load-use hazards, branch flushes and multi-cycle stall requests. It freezes its contents under downstream hold, and generates the fetch/decode stall that the upstream registers obey.

## Interface

Parameters:
- CTRL_W, 32: width of packed control bundle (RegDst, ALUOp, MemRead, … packed by decoder)
- INSTR_W, 32: instruction width
- PC_W, 32: PC width
- MAX_STALL, 4: largest multi-cycle stall length in bubbles (≥2)
- CNT_W, 16: bubble counter width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- ctrl_in  in  CTRL_W  decoded control bundle from ID
- instr_in  in  INSTR_W  instruction from IF/ID
- pc_in  in  PC_W  PC of instr_in
- valid_in  in  1  ID slot holds a real instruction
- hazard  in  1  load-use hazard; insert one bubble
- multi_stall_req  in  1  insert N bubbles
- multi_stall_len  in  $clog2(MAX_STALL+1)  N for multi_stall_req
- flush  in  1  branch/jump taken; kill ID slot
- hold  in  1  downstream stall; freeze register
- ctrl_out  out  CTRL_W  registered control bundle to EX
- instr_out  out  INSTR_W  registered instruction
- pc_out  out  PC_W  registered PC
- valid_out  out  1  EX slot holds a real instruction
- bubble_out  out  1  EX slot holds an inserted bubble
- stall_fetch  out  1  combinational; IF/ID must hold this cycle
- bubble_count  out  CNT_W  bubbles inserted (only with BUBBLE_COUNT_EN)

## Operation

- States: RUN, STALL. The 2-bit-min down-counter `cnt` is used only in STALL.
- Bubble load: ctrl_out=0, instr_out=0, pc_out=0, valid_out=0, bubble_out=1.
- Capture: outputs take the *_in values. valid_out=valid_in, bubble_out=0.
- Priority, highest first: Reset > flush > hold > hazard > multi_stall_req > capture.
- Behaviour in RUN:
  - flush: bubble load. Stay in RUN.
  - hold: all registers and state unchanged.
  - hazard: bubble load. Stay in RUN. multi_stall_req is ignored this cycle.
  - multi_stall_req: compute N_eff = clamp(multi_stall_len, 1, MAX_STALL). Bubble load. If N_eff≥2, go to STALL with cnt=N_eff−1.
  - otherwise: capture.
- Behaviour in STALL:
  - flush: bubble load. Go to RUN with cnt=0.
  - hold: registers, state and cnt unchanged.
  - otherwise: bubble load. If cnt==1, go to RUN; else cnt−1.
  - hazard and multi_stall_req are ignored.
- stall_fetch = !flush & (hold | state==STALL | (state==RUN & (hazard | multi_stall_req))).

## Timing

- Latency: one cycle from *_in to *_out on capture.
- A multi-stall of N_eff bubbles produces exactly N_eff consecutive bubble cycles at the outputs, assuming no hold.
  - stall_fetch is high for those N_eff cycles.
  - The held instruction is captured on the edge after stall_fetch falls.
- hold stretches any sequence cycle-for-cycle and never drops or duplicates bubbles.
- Reset: outputs 0, valid_out=0, bubble_out=0, state=RUN, cnt=0, bubble_count=0. Reset asserted in STALL aborts the stall on that edge.
- Simultaneous flush+hold: flush wins (bubble loaded). Simultaneous hazard+multi_stall_req in RUN: single bubble; the requester must re-assert.

## Configuration

- BUBBLE_COUNT_EN defined:
  - bubble_count increments by 1 on every edge where a bubble is loaded, from any cause.
  - It saturates at 2^CNT_W−1 and is cleared by Reset.
- BUBBLE_COUNT_EN not defined: bubble_count is tied to 0 and no counter flops exist.

## Test plan

- Capture: ctrl_in=0x0000_00A5, instr_in=0x8C22_0004, pc_in=0x40 with no controls → the next cycle shows the same values, valid_out=1, bubble_out=0.
- Load-use: hazard=1 for one cycle with instr_in=X → the next cycle shows zeros and bubble_out=1, stall_fetch=1 for that cycle, and X is captured the cycle after.
- Multi-stall: multi_stall_req=1, len=3, with hold=1 in the second bubble cycle → 4 bubble cycles, stall_fetch high for 4 cycles, then capture.
- Clamp: len=0 → 1 bubble. len=7 with MAX_STALL=4 → 4 bubbles.
- Flush mid-STALL with len=4 at the second bubble → bubbles continue only through the flush edge, state=RUN, capture resumes the next cycle.
- Counter (BUBBLE_COUNT_EN, CNT_W=2): 5 hazards → bubble_count saturates at 3. Reset → 0.

Source files
------------

// File: rtl/id_ex_bubble_reg.sv
// ID/EX pipeline register with bubble insertion for load-use hazards,
// branch flushes and multi-cycle stall requests, plus the IF/ID stall.
// Optional feature macro: BUBBLE_COUNT_EN enables a saturating counter
// of inserted bubbles on bubble_count; without it bubble_count is 0.
module id_ex_bubble_reg #(
    parameter int CTRL_W    = 32,
    parameter int INSTR_W   = 32,
    parameter int PC_W      = 32,
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 16
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [CTRL_W-1:0]                ctrl_in,
    input  logic [INSTR_W-1:0]               instr_in,
    input  logic [PC_W-1:0]                  pc_in,
    input  logic                             valid_in,
    input  logic                             hazard,
    input  logic                             multi_stall_req,
    input  logic [$clog2(MAX_STALL+1)-1:0]   multi_stall_len,
    input  logic                             flush,
    input  logic                             hold,
    output logic [CTRL_W-1:0]                ctrl_out,
    output logic [INSTR_W-1:0]               instr_out,
    output logic [PC_W-1:0]                  pc_out,
    output logic                             valid_out,
    output logic                             bubble_out,
    output logic                             stall_fetch,
    output logic [CNT_W-1:0]                 bubble_count
);

    localparam int LEN_W = $clog2(MAX_STALL + 1);
    // Stall down-counter is at least two bits wide.
    localparam int SC_W  = (LEN_W > 2) ? LEN_W : 2;

    typedef enum logic {RUN, STALL} state_t;

    state_t              state;
    logic [SC_W-1:0]     cnt;
    logic [CTRL_W-1:0]   ctrl_p1;
    logic [INSTR_W-1:0]  instr_p1;
    logic [PC_W-1:0]     pc_p1;
    logic                vld_p1;
    logic                bubble_p1;
    logic                load_bubble;
    logic                capture;
    logic [SC_W-1:0]     n_eff;

    // Requested stall length forced into 1..MAX_STALL.
    function automatic logic [SC_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0)
            return SC_W'(1);
        else if (int'(len) > MAX_STALL)
            return SC_W'(MAX_STALL);
        else
            return SC_W'(len);
    endfunction

    assign n_eff = clamp_len(multi_stall_len);

    // Decide whether this edge loads a bubble, captures ID, or freezes.
    always_comb begin
        load_bubble = 1'b0;
        capture     = 1'b0;
        if (flush)
            load_bubble = 1'b1;
        else if (hold)
            load_bubble = 1'b0;
        else if (state == RUN) begin
            if (hazard || multi_stall_req)
                load_bubble = 1'b1;
            else
                capture = 1'b1;
        end else
            load_bubble = 1'b1;
    end

    // IF/ID must hold whenever this register will not consume the ID slot.
    assign stall_fetch = !flush &&
                         (hold || (state == STALL) ||
                          ((state == RUN) && (hazard || multi_stall_req)));

    // ID -> EX boundary: payload registers and the bubble sequencer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ctrl_p1   <= '0;
            instr_p1  <= '0;
            pc_p1     <= '0;
            vld_p1    <= 1'b0;
            bubble_p1 <= 1'b0;
            state     <= RUN;
            cnt       <= '0;
        end else begin
            if (load_bubble) begin
                ctrl_p1   <= '0;
                instr_p1  <= '0;
                pc_p1     <= '0;
                vld_p1    <= 1'b0;
                bubble_p1 <= 1'b1;
            end else if (capture) begin
                ctrl_p1   <= ctrl_in;
                instr_p1  <= instr_in;
                pc_p1     <= pc_in;
                vld_p1    <= valid_in;
                bubble_p1 <= 1'b0;
            end

            if (flush) begin
                state <= RUN;
                cnt   <= '0;
            end else if (!hold) begin
                if (state == RUN) begin
                    if (!hazard && multi_stall_req && (n_eff >= SC_W'(2))) begin
                        state <= STALL;
                        cnt   <= n_eff - SC_W'(1);
                    end
                end else begin
                    if (cnt == SC_W'(1)) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else
                        cnt <= cnt - SC_W'(1);
                end
            end
        end
    end

    assign ctrl_out   = ctrl_p1;
    assign instr_out  = instr_p1;
    assign pc_out     = pc_p1;
    assign valid_out  = vld_p1;
    assign bubble_out = bubble_p1;

`ifdef BUBBLE_COUNT_EN
    logic [CNT_W-1:0] bubble_count_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating count of every bubble loaded, whatever its cause.
    always_ff @(posedge Clk) begin
        if (Reset)
            bubble_count_p1 <= '0;
        else if (load_bubble)
            bubble_count_p1 <= sat_inc(bubble_count_p1);
    end

    assign bubble_count = bubble_count_p1;
`else
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_bubble_reg.sv
// Directed bench for id_ex_bubble_reg (MAX_STALL=4, CNT_W=2).
module tb_id_ex_bubble_reg;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] ctrl_in, instr_in, pc_in;
    logic        valid_in, hazard, multi_stall_req, flush, hold;
    logic [2:0]  multi_stall_len;
    logic [31:0] ctrl_out, instr_out, pc_out;
    logic        valid_out, bubble_out, stall_fetch;
    logic [1:0]  bubble_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    id_ex_bubble_reg #(
        .CTRL_W(32), .INSTR_W(32), .PC_W(32), .MAX_STALL(4), .CNT_W(2)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .ctrl_in(ctrl_in), .instr_in(instr_in), .pc_in(pc_in),
        .valid_in(valid_in), .hazard(hazard),
        .multi_stall_req(multi_stall_req), .multi_stall_len(multi_stall_len),
        .flush(flush), .hold(hold),
        .ctrl_out(ctrl_out), .instr_out(instr_out), .pc_out(pc_out),
        .valid_out(valid_out), .bubble_out(bubble_out),
        .stall_fetch(stall_fetch), .bubble_count(bubble_count)
    );

    always #5 Clk = ~Clk;

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        ctrl_in = '0; instr_in = '0; pc_in = '0; valid_in = 1'b0;
        hazard = 1'b0; multi_stall_req = 1'b0; multi_stall_len = '0;
        flush = 1'b0; hold = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        total_cnt++;
        if ({ctrl_out, instr_out, pc_out} !== 96'd0 || valid_out !== 1'b0 || bubble_out !== 1'b0)
            $display("FAIL reset_outputs got ctrl=%h instr=%h pc=%h v=%b b=%b required all 0",
                     ctrl_out, instr_out, pc_out, valid_out, bubble_out);
        else pass_cnt++;
        total_cnt++;
        if (stall_fetch !== 1'b0) $display("FAIL reset_stall got %b required 0", stall_fetch);
        else pass_cnt++;
        total_cnt++;
        if (bubble_count !== 2'd0) $display("FAIL reset_count got %0d required 0", bubble_count);
        else pass_cnt++;
    endtask

    task automatic test_capture();
        ctrl_in = 32'h0000_00A5; instr_in = 32'h8C22_0004; pc_in = 32'h40; valid_in = 1'b1;
        step();
        total_cnt++;
        if (ctrl_out !== 32'h0000_00A5 || instr_out !== 32'h8C22_0004 || pc_out !== 32'h40)
            $display("FAIL capture_data got ctrl=%h instr=%h pc=%h required 000000a5 8c220004 00000040",
                     ctrl_out, instr_out, pc_out);
        else pass_cnt++;
        total_cnt++;
        if (valid_out !== 1'b1 || bubble_out !== 1'b0)
            $display("FAIL capture_flags got v=%b b=%b required v=1 b=0", valid_out, bubble_out);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        ctrl_in = 32'h33; instr_in = 32'h1111_2222; pc_in = 32'h44; valid_in = 1'b1;
        hazard = 1'b1;
        #1;
        total_cnt++;
        if (stall_fetch !== 1'b1) $display("FAIL hazard_stall got %b required 1", stall_fetch);
        else pass_cnt++;
        step();
        hazard = 1'b0;
        total_cnt++;
        if (bubble_out !== 1'b1 || valid_out !== 1'b0 || instr_out !== 32'd0 || ctrl_out !== 32'd0)
            $display("FAIL hazard_bubble got b=%b v=%b instr=%h ctrl=%h required b=1 v=0 zeros",
                     bubble_out, valid_out, instr_out, ctrl_out);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (stall_fetch !== 1'b0) $display("FAIL hazard_release got %b required 0", stall_fetch);
        else pass_cnt++;
        step();
        total_cnt++;
        if (instr_out !== 32'h1111_2222 || pc_out !== 32'h44 || valid_out !== 1'b1 || bubble_out !== 1'b0)
            $display("FAIL hazard_recapture got instr=%h pc=%h v=%b b=%b required 11112222 00000044 1 0",
                     instr_out, pc_out, valid_out, bubble_out);
        else pass_cnt++;
    endtask

    task automatic test_multi_stall();
        instr_in = 32'hABCD_0001; pc_in = 32'h48; valid_in = 1'b1;
        multi_stall_req = 1'b1; multi_stall_len = 3'd3;
        #1;
        total_cnt++;
        if (stall_fetch !== 1'b1) $display("FAIL ms_stall_c0 got %b required 1", stall_fetch);
        else pass_cnt++;
        step();
        multi_stall_req = 1'b0;
        total_cnt++;
        if (bubble_out !== 1'b1) $display("FAIL ms_bubble_c1 got %b required 1", bubble_out);
        else pass_cnt++;
        for (int k = 1; k <= 3; k++) begin
            hold = (k == 2);
            #1;
            total_cnt++;
            if (stall_fetch !== 1'b1) $display("FAIL ms_stall_c%0d got %b required 1", k, stall_fetch);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bubble_out !== 1'b1 || valid_out !== 1'b0)
                $display("FAIL ms_bubble_c%0d got b=%b v=%b required b=1 v=0", k + 1, bubble_out, valid_out);
            else pass_cnt++;
        end
        hold = 1'b0;
        #1;
        total_cnt++;
        if (stall_fetch !== 1'b0) $display("FAIL ms_stall_end got %b required 0", stall_fetch);
        else pass_cnt++;
        step();
        total_cnt++;
        if (instr_out !== 32'hABCD_0001 || valid_out !== 1'b1 || bubble_out !== 1'b0)
            $display("FAIL ms_capture got instr=%h v=%b b=%b required abcd0001 1 0",
                     instr_out, valid_out, bubble_out);
        else pass_cnt++;
    endtask

    // Issue a stall request of length len and expect exp_n bubble cycles.
    task automatic run_clamp(input logic [2:0] len, input int exp_n);
        instr_in = 32'h5000_0000 | 32'(len); valid_in = 1'b1;
        multi_stall_req = 1'b1; multi_stall_len = len;
        for (int k = 0; k < exp_n; k++) begin
            #1;
            total_cnt++;
            if (stall_fetch !== 1'b1) $display("FAIL clamp%0d_stall_c%0d got %b required 1", len, k, stall_fetch);
            else pass_cnt++;
            step();
            multi_stall_req = 1'b0;
            total_cnt++;
            if (bubble_out !== 1'b1) $display("FAIL clamp%0d_bubble_c%0d got %b required 1", len, k, bubble_out);
            else pass_cnt++;
        end
        #1;
        total_cnt++;
        if (stall_fetch !== 1'b0) $display("FAIL clamp%0d_stall_end got %b required 0", len, stall_fetch);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bubble_out !== 1'b0 || instr_out !== (32'h5000_0000 | 32'(len)))
            $display("FAIL clamp%0d_capture got b=%b instr=%h required 0 %h", len, bubble_out,
                     instr_out, 32'h5000_0000 | 32'(len));
        else pass_cnt++;
    endtask

    task automatic test_clamp();
        run_clamp(3'd0, 1);
        run_clamp(3'd7, 4);
    endtask

    task automatic test_flush();
        instr_in = 32'hF1F1_0000; pc_in = 32'h60; valid_in = 1'b1;
        multi_stall_req = 1'b1; multi_stall_len = 3'd4;
        step();
        multi_stall_req = 1'b0;
        step();
        total_cnt++;
        if (bubble_out !== 1'b1) $display("FAIL flush_pre_bubble got %b required 1", bubble_out);
        else pass_cnt++;
        flush = 1'b1;
        #1;
        total_cnt++;
        if (stall_fetch !== 1'b0) $display("FAIL flush_stall got %b required 0", stall_fetch);
        else pass_cnt++;
        step();
        flush = 1'b0;
        total_cnt++;
        if (bubble_out !== 1'b1) $display("FAIL flush_bubble got %b required 1", bubble_out);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (stall_fetch !== 1'b0) $display("FAIL flush_run_state got %b required 0", stall_fetch);
        else pass_cnt++;
        step();
        total_cnt++;
        if (instr_out !== 32'hF1F1_0000 || valid_out !== 1'b1 || bubble_out !== 1'b0)
            $display("FAIL flush_resume got instr=%h v=%b b=%b required f1f10000 1 0",
                     instr_out, valid_out, bubble_out);
        else pass_cnt++;
        // flush and hold together: flush wins
        flush = 1'b1; hold = 1'b1;
        step();
        flush = 1'b0; hold = 1'b0;
        total_cnt++;
        if (bubble_out !== 1'b1 || instr_out !== 32'd0)
            $display("FAIL flush_hold got b=%b instr=%h required 1 0", bubble_out, instr_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_stall();
        multi_stall_req = 1'b1; multi_stall_len = 3'd4;
        step();
        multi_stall_req = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        total_cnt++;
        if (bubble_out !== 1'b0 || stall_fetch !== 1'b0)
            $display("FAIL reset_in_stall got b=%b sf=%b required 0 0", bubble_out, stall_fetch);
        else pass_cnt++;
    endtask

    task automatic test_counter();
        logic [1:0] exp_sat;
`ifdef BUBBLE_COUNT_EN
        exp_sat = 2'd3;
`else
        exp_sat = 2'd0;
`endif
        clear_inputs();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        total_cnt++;
        if (bubble_count !== 2'd0) $display("FAIL count_reset got %0d required 0", bubble_count);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            hazard = 1'b1;
            step();
        end
        hazard = 1'b0;
        total_cnt++;
        if (bubble_count !== exp_sat) $display("FAIL count_sat got %0d required %0d", bubble_count, exp_sat);
        else pass_cnt++;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        total_cnt++;
        if (bubble_count !== 2'd0) $display("FAIL count_clear got %0d required 0", bubble_count);
        else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b1;
        test_reset();
        test_capture();
        test_load_use();
        test_multi_stall();
        test_clamp();
        test_flush();
        test_reset_in_stall();
        test_counter();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
